shadow_unloader: RTL and testbench

Controller and deserializer for the far end of a shadow capture chain. On request, it issues a one-cycle capture to the chain and waits for the chain's ready flag. It then drives the chain's dump enable and samples the serial bit stream. Bits are reassembled MSB-first into WORD_WIDTH-bit words and presented on a valid/ready port toward the debug readout path (UART/FIFO).

---
 rtl/shadow_unloader.sv | 190 +++++++++++++++++++
 tb/tb_shadow_unloader.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shadow_unloader.sv
// shadow_unloader
//   Far-end controller for a shadow capture chain. On start it pulses a
//   one-cycle capture, waits for the chain's ready pulse, then enables the
//   dump and deserialises the MSB-first bit stream into WORD_WIDTH-bit words
//   presented on a valid/ready port. A trailing partial word is
//   left-justified. last marks the final word of an unload.
//
//   Optional build macro: SHADOW_UNLOADER_TIMEOUT_EN
//     defined   -> WAIT_RDY gives up after READY_TIMEOUT cycles (err=1, IDLE)
//     undefined -> WAIT_RDY waits forever, no timeout counter
//
// Ports
//   clk         system clock (also clocks the chain while dumping)
//   rst         asynchronous reset, active low
//   start       request capture + unload (honoured in IDLE only)
//   c_en        capture enable to chain (one cycle)
//   d_en        dump enable to chain (chain shifts one bit per clk while high)
//   s_in        serial data from chain, MSB first
//   s_ready     chain data-ready pulse
//   s_done      chain dump-done flag, checked after the unload
//   word        assembled output word
//   word_valid  word is valid
//   word_ready  consumer accepts word
//   busy        controller not in IDLE
//   last        final word of the unload (qualified by word_valid)
//   err         sticky error, cleared by the next accepted start
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for start
// CAPTURE   | c_en high for one cycle
// WAIT_RDY  | waiting for s_ready (optionally with timeout)
// SHIFT     | d_en high while assembly register has room, sampling s_in
// FLUSH     | push trailing / held word, wait for output slot to drain
// CHECK     | flag err if the chain did not report dump-done

module shadow_unloader #(
  parameter int CHAIN_LEN     = 32,
  parameter int WORD_WIDTH    = 8,
  parameter int COUNT_WIDTH   = 16,
  parameter int READY_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  c_en,
  output logic                  d_en,
  input  logic                  s_in,
  input  logic                  s_ready,
  input  logic                  s_done,
  output logic [WORD_WIDTH-1:0] word,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic                  busy,
  output logic                  last,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_WAIT_RDY, S_SHIFT, S_FLUSH, S_CHECK
  } state_t;

  localparam int                     FILL_W    = $clog2(WORD_WIDTH + 1);
  localparam logic [FILL_W-1:0]      FILL_FULL = FILL_W'(WORD_WIDTH);
  localparam logic [COUNT_WIDTH-1:0] LAST_BIT  = COUNT_WIDTH'(CHAIN_LEN - 1);

  if (CHAIN_LEN < 1 || WORD_WIDTH < 1 || WORD_WIDTH > CHAIN_LEN ||
      (64'd1 << COUNT_WIDTH) <= 64'(CHAIN_LEN) || READY_TIMEOUT < 1) begin : g_param_chk
    $error("shadow_unloader: illegal parameter combination");
  end

  state_t                  state, state_nx;
  logic [COUNT_WIDTH-1:0]  bit_cnt;
  logic [FILL_W-1:0]       fill;
  logic [WORD_WIDTH-1:0]   asm_reg;
  logic [WORD_WIDTH-1:0]   asm_nx;
  logic                    slot_free;
  logic                    last_sample;
  logic                    tmo_hit;

  assign slot_free   = !word_valid || word_ready;
  assign asm_nx      = (asm_reg << 1) | WORD_WIDTH'(s_in);
  assign last_sample = d_en && (bit_cnt == LAST_BIT);

`ifdef SHADOW_UNLOADER_TIMEOUT_EN
  logic [COUNT_WIDTH-1:0] tmo_cnt;

  // WAIT_RDY is only entered from CAPTURE, so clearing there restarts the count on entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    tmo_cnt <= '0;
    else if (state == S_CAPTURE) tmo_cnt <= '0;
    else if (state == S_WAIT_RDY) tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (state == S_WAIT_RDY) && !s_ready &&
                   (tmo_cnt == COUNT_WIDTH'(READY_TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (start) state_nx = S_CAPTURE;
      S_CAPTURE:  state_nx = S_WAIT_RDY;
      S_WAIT_RDY: if (s_ready) state_nx = S_SHIFT;
                  else if (tmo_hit) state_nx = S_IDLE;
      S_SHIFT:    if (last_sample) state_nx = S_FLUSH;
      S_FLUSH:    if (fill == '0 && !word_valid) state_nx = S_CHECK;
      S_CHECK:    state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  // d_en depends only on registered state: a full assembly register means the
  // slot was occupied when the word completed, so the dump pauses one cycle
  // while the held word moves out.
  always_comb begin
    c_en = (state == S_CAPTURE);
    d_en = (state == S_SHIFT) && (fill != FILL_FULL);
    busy = (state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt    <= '0;
      fill       <= '0;
      asm_reg    <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      last       <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (word_valid && word_ready) begin
        word_valid <= 1'b0;
        last       <= 1'b0;
      end
      case (state)
        S_IDLE: if (start) err <= 1'b0;
        S_CAPTURE: begin
          bit_cnt <= '0;
          fill    <= '0;
          asm_reg <= '0;
        end
        S_WAIT_RDY: if (tmo_hit) err <= 1'b1;
        S_SHIFT: begin
          if (d_en) begin
            bit_cnt <= bit_cnt + 1'b1;
            // completing bit goes straight to the slot when possible, so a
            // free-running consumer never stalls the dump
            if ((fill + 1'b1 == FILL_FULL) && slot_free) begin
              word       <= asm_nx;
              word_valid <= 1'b1;
              last       <= last_sample;
              fill       <= '0;
              asm_reg    <= '0;
            end else begin
              asm_reg <= asm_nx;
              fill    <= fill + 1'b1;
            end
          end else if (slot_free) begin
            word       <= asm_reg;
            word_valid <= 1'b1;
            last       <= 1'b0;
            fill       <= '0;
            asm_reg    <= '0;
          end
        end
        S_FLUSH: begin
          // covers both a trailing partial word and a held final full word
          if (fill != '0 && slot_free) begin
            word       <= asm_reg << (FILL_FULL - fill);
            word_valid <= 1'b1;
            last       <= 1'b1;
            fill       <= '0;
            asm_reg    <= '0;
          end
        end
        S_CHECK: if (!s_done) err <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shadow_unloader.sv
module tb_shadow_unloader;

  localparam int CL = 20;
  localparam int WW = 8;
  localparam int NW = (CL + WW - 1) / WW;
  localparam int RT = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic s_ready = 1'b0;
  logic s_in, s_done, c_en, d_en, word_valid, busy, last, err;
  logic word_ready = 1'b0;
  logic [WW-1:0] word;

  logic wr_force = 1'b1;
  logic rand_mode = 1'b0;
  logic done_ok = 1'b1;
  logic [CL-1:0] cap_val = '0;
  logic [CL-1:0] chain = '0;
  int pos = 0;

  int n_cmp = 0;
  int n_bad = 0;
  int den_cnt = 0, cen_cnt = 0, wv_cnt = 0, stab_err = 0;
  logic [WW:0] got_w[$];
  logic prev_hold = 1'b0;
  logic [WW:0] prev_out = '0;

  always #5 clk = ~clk;

  shadow_unloader #(.CHAIN_LEN(CL), .WORD_WIDTH(WW), .COUNT_WIDTH(16), .READY_TIMEOUT(RT)) dut (
    .clk(clk), .rst(rst), .start(start), .c_en(c_en), .d_en(d_en), .s_in(s_in),
    .s_ready(s_ready), .s_done(s_done), .word(word), .word_valid(word_valid),
    .word_ready(word_ready), .busy(busy), .last(last), .err(err)
  );

  // chain model: captures on c_en, shifts MSB first while d_en, holds otherwise
  assign s_in   = (pos < CL) ? chain[CL-1-pos] : 1'b0;
  assign s_done = done_ok && (pos == CL);

  always @(posedge clk) begin
    if (c_en) begin
      chain <= cap_val;
      pos   <= 0;
    end else if (d_en && pos < CL) begin
      pos <= pos + 1;
    end
  end

  always @(posedge clk) begin
    if (d_en) den_cnt <= den_cnt + 1;
    if (c_en) cen_cnt <= cen_cnt + 1;
    if (word_valid) wv_cnt <= wv_cnt + 1;
    if (word_valid && word_ready) got_w.push_back({last, word});
    if (prev_hold && (!word_valid || {last, word} != prev_out)) stab_err <= stab_err + 1;
    prev_hold <= word_valid && !word_ready;
    prev_out  <= {last, word};
  end

  always @(negedge clk) word_ready <= rand_mode ? 1'($urandom_range(0, 1)) : wr_force;

  // reference: left-justify the chain value into NW*WW bits and cut MSB first
  function automatic logic [WW:0] ref_word(input logic [CL-1:0] v, input int i);
    longint unsigned padded, w;
    padded = longint'(v) << (NW * WW - CL);
    w = (padded >> ((NW - 1 - i) * WW)) & ((64'd1 << WW) - 1);
    return {(i == NW - 1), w[WW-1:0]};
  endfunction

  task automatic wait_idle(input int limit);
    int cyc = 0;
    while (busy && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_unload(input logic [CL-1:0] v, input int rdelay);
    cap_val = v;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (rdelay + 1) @(negedge clk);
    s_ready = 1'b1;
    @(negedge clk) s_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp += 7;
    if (c_en !== 1'b0)       begin n_bad++; $display("FAIL reset_c_en: got %b expected 0", c_en); end
    if (d_en !== 1'b0)       begin n_bad++; $display("FAIL reset_d_en: got %b expected 0", d_en); end
    if (word !== '0)         begin n_bad++; $display("FAIL reset_word: got %h expected 00", word); end
    if (word_valid !== 1'b0) begin n_bad++; $display("FAIL reset_word_valid: got %b expected 0", word_valid); end
    if (busy !== 1'b0)       begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (last !== 1'b0)       begin n_bad++; $display("FAIL reset_last: got %b expected 0", last); end
    if (err !== 1'b0)        begin n_bad++; $display("FAIL reset_err: got %b expected 0", err); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_after: busy got %b expected 0", busy); end
  endtask

  task automatic test_basic();
    int base = got_w.size();
    int d0 = den_cnt;
    int c0 = cen_cnt;
    logic [CL-1:0] v = 20'hABCDE;
    wr_force = 1'b1;
    cap_val = v;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n_cmp += 2;
    if (c_en !== 1'b1) begin n_bad++; $display("FAIL basic_c_en_high: got %b expected 1", c_en); end
    if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b expected 1", busy); end
    @(negedge clk);
    n_cmp++;
    if (c_en !== 1'b0) begin n_bad++; $display("FAIL basic_c_en_one_cycle: got %b expected 0", c_en); end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (d_en !== 1'b0) begin n_bad++; $display("FAIL basic_d_en_wait: got %b expected 0", d_en); end
    s_ready = 1'b1;
    @(negedge clk) s_ready = 1'b0;
    n_cmp++;
    if (d_en !== 1'b1) begin n_bad++; $display("FAIL basic_d_en_start: got %b expected 1", d_en); end
    wait_idle(CL + 10);
    n_cmp += 4;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_idle_bound: busy got %b expected 0", busy); end
    if (den_cnt - d0 != CL) begin n_bad++; $display("FAIL basic_d_en_cycles: got %0d expected %0d", den_cnt - d0, CL); end
    if (cen_cnt - c0 != 1) begin n_bad++; $display("FAIL basic_c_en_pulses: got %0d expected 1", cen_cnt - c0); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL basic_err: got %b expected 0", err); end
    n_cmp++;
    if (got_w.size() - base != NW) begin n_bad++; $display("FAIL basic_count: got %0d expected %0d", got_w.size() - base, NW); end
    else for (int i = 0; i < NW; i++) begin
      n_cmp++;
      if (got_w[base+i] !== ref_word(v, i)) begin
        n_bad++; $display("FAIL basic_word%0d: got {last,word} %h expected %h", i, got_w[base+i], ref_word(v, i));
      end
    end
  endtask

  task automatic test_stall();
    int base = got_w.size();
    int d0 = den_cnt;
    int s0 = stab_err;
    logic [CL-1:0] v = CL'($urandom);
    logic [WW:0] w0 = ref_word(v, 0);
    wr_force = 1'b0;
    repeat (2) @(negedge clk);
    run_unload(v, 2);
    repeat (30) @(negedge clk);
    n_cmp += 5;
    if (d_en !== 1'b0) begin n_bad++; $display("FAIL stall_d_en: got %b expected 0", d_en); end
    if (busy !== 1'b1) begin n_bad++; $display("FAIL stall_busy: got %b expected 1", busy); end
    if (den_cnt - d0 != 2 * WW) begin n_bad++; $display("FAIL stall_bits: got %0d expected %0d", den_cnt - d0, 2 * WW); end
    if (word_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid: got %b expected 1", word_valid); end
    if (word !== w0[WW-1:0]) begin n_bad++; $display("FAIL stall_word: got %h expected %h", word, w0[WW-1:0]); end
    wr_force = 1'b1;
    wait_idle(60);
    n_cmp += 3;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL stall_idle_bound: busy got %b expected 0", busy); end
    if (den_cnt - d0 != CL) begin n_bad++; $display("FAIL stall_d_en_cycles: got %0d expected %0d", den_cnt - d0, CL); end
    if (stab_err != s0) begin n_bad++; $display("FAIL stall_hold_stable: got %0d changes expected 0", stab_err - s0); end
    n_cmp++;
    if (got_w.size() - base != NW) begin n_bad++; $display("FAIL stall_count: got %0d expected %0d", got_w.size() - base, NW); end
    else for (int i = 0; i < NW; i++) begin
      n_cmp++;
      if (got_w[base+i] !== ref_word(v, i)) begin
        n_bad++; $display("FAIL stall_word%0d: got {last,word} %h expected %h", i, got_w[base+i], ref_word(v, i));
      end
    end
  endtask

  task automatic test_random();
    int s0 = stab_err;
    for (int it = 0; it < 6; it++) begin
      int base = got_w.size();
      int d0 = den_cnt;
      int c0 = cen_cnt;
      logic [CL-1:0] v = CL'($urandom);
      rand_mode = 1'b1;
      run_unload(v, $urandom_range(1, 6));
      wait_idle(300);
      rand_mode = 1'b0;
      n_cmp += 4;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL rand%0d_idle_bound: busy got %b expected 0", it, busy); end
      if (den_cnt - d0 != CL) begin n_bad++; $display("FAIL rand%0d_d_en_cycles: got %0d expected %0d", it, den_cnt - d0, CL); end
      if (cen_cnt - c0 != 1) begin n_bad++; $display("FAIL rand%0d_c_en_pulses: got %0d expected 1", it, cen_cnt - c0); end
      if (err !== 1'b0) begin n_bad++; $display("FAIL rand%0d_err: got %b expected 0", it, err); end
      n_cmp++;
      if (got_w.size() - base != NW) begin n_bad++; $display("FAIL rand%0d_count: got %0d expected %0d", it, got_w.size() - base, NW); end
      else for (int i = 0; i < NW; i++) begin
        n_cmp++;
        if (got_w[base+i] !== ref_word(v, i)) begin
          n_bad++; $display("FAIL rand%0d_word%0d: got {last,word} %h expected %h", it, i, got_w[base+i], ref_word(v, i));
        end
      end
    end
    n_cmp++;
    if (stab_err != s0) begin n_bad++; $display("FAIL rand_hold_stable: got %0d changes expected 0", stab_err - s0); end
  endtask

  task automatic test_reset_mid();
    int base;
    int d0 = den_cnt;
    int k = 0;
    logic [CL-1:0] v = CL'($urandom);
    wr_force = 1'b1;
    run_unload(CL'($urandom), 2);
    while (den_cnt - d0 < 7 && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (den_cnt - d0 != 7) begin n_bad++; $display("FAIL rstmid_reach7: got %0d bits expected 7", den_cnt - d0); end
    base = got_w.size();
    rst = 1'b0;
    #1;
    n_cmp += 6;
    if (c_en !== 1'b0)       begin n_bad++; $display("FAIL rstmid_c_en: got %b expected 0", c_en); end
    if (d_en !== 1'b0)       begin n_bad++; $display("FAIL rstmid_d_en: got %b expected 0", d_en); end
    if (busy !== 1'b0)       begin n_bad++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    if (word_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %b expected 0", word_valid); end
    if (word !== '0)         begin n_bad++; $display("FAIL rstmid_word: got %h expected 00", word); end
    if (last !== 1'b0)       begin n_bad++; $display("FAIL rstmid_last: got %b expected 0", last); end
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    d0 = den_cnt;
    run_unload(v, 1);
    wait_idle(CL + 10);
    n_cmp += 2;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_idle_bound: busy got %b expected 0", busy); end
    if (den_cnt - d0 != CL) begin n_bad++; $display("FAIL rstmid_d_en_cycles: got %0d expected %0d", den_cnt - d0, CL); end
    n_cmp++;
    if (got_w.size() - base != NW) begin n_bad++; $display("FAIL rstmid_count: got %0d expected %0d", got_w.size() - base, NW); end
    else for (int i = 0; i < NW; i++) begin
      n_cmp++;
      if (got_w[base+i] !== ref_word(v, i)) begin
        n_bad++; $display("FAIL rstmid_word%0d: got {last,word} %h expected %h", i, got_w[base+i], ref_word(v, i));
      end
    end
  endtask

  task automatic test_sdone_fault();
    int base = got_w.size();
    logic [CL-1:0] v = CL'($urandom);
    wr_force = 1'b1;
    done_ok = 1'b0;
    run_unload(v, 3);
    wait_idle(CL + 10);
    n_cmp += 2;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL sdone_idle_bound: busy got %b expected 0", busy); end
    if (err !== 1'b1) begin n_bad++; $display("FAIL sdone_err_set: got %b expected 1", err); end
    n_cmp++;
    if (got_w.size() - base != NW) begin n_bad++; $display("FAIL sdone_count: got %0d expected %0d", got_w.size() - base, NW); end
    else for (int i = 0; i < NW; i++) begin
      n_cmp++;
      if (got_w[base+i] !== ref_word(v, i)) begin
        n_bad++; $display("FAIL sdone_word%0d: got {last,word} %h expected %h", i, got_w[base+i], ref_word(v, i));
      end
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL sdone_err_sticky: got %b expected 1", err); end
    done_ok = 1'b1;
    cap_val = CL'($urandom);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL sdone_err_clear: got %b expected 0", err); end
    @(negedge clk) s_ready = 1'b1;
    @(negedge clk) s_ready = 1'b0;
    wait_idle(CL + 10);
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL sdone_err_after_good: got %b expected 0", err); end
  endtask

  task automatic test_start_ignored();
    int base = got_w.size();
    int d0 = den_cnt;
    int c0 = cen_cnt;
    int k = 0;
    logic [CL-1:0] v = CL'($urandom);
    wr_force = 1'b1;
    cap_val = v;
    @(negedge clk) start = 1'b1;
    do begin
      @(negedge clk);
      k++;
      start   = busy ? 1'($urandom_range(0, 1)) : 1'b0;
      s_ready = busy ? 1'($urandom_range(0, 1)) : 1'b0;
    end while (busy && k < 300);
    start = 1'b0;
    s_ready = 1'b0;
    @(negedge clk);
    n_cmp += 3;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL ignore_idle_bound: busy got %b expected 0", busy); end
    if (cen_cnt - c0 != 1) begin n_bad++; $display("FAIL ignore_c_en_pulses: got %0d expected 1", cen_cnt - c0); end
    if (den_cnt - d0 != CL) begin n_bad++; $display("FAIL ignore_d_en_cycles: got %0d expected %0d", den_cnt - d0, CL); end
    n_cmp++;
    if (got_w.size() - base != NW) begin n_bad++; $display("FAIL ignore_count: got %0d expected %0d", got_w.size() - base, NW); end
    else for (int i = 0; i < NW; i++) begin
      n_cmp++;
      if (got_w[base+i] !== ref_word(v, i)) begin
        n_bad++; $display("FAIL ignore_word%0d: got {last,word} %h expected %h", i, got_w[base+i], ref_word(v, i));
      end
    end
  endtask

  task automatic test_timeout();
    int w0 = wv_cnt;
    cap_val = CL'($urandom);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
`ifdef SHADOW_UNLOADER_TIMEOUT_EN
    begin
      int k = 0;
      while (busy && k < 400) begin
        @(negedge clk);
        k++;
      end
      n_cmp += 4;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL tmo_idle: busy got %b expected 0", busy); end
      if (k - 1 != RT) begin n_bad++; $display("FAIL tmo_cycles: got %0d expected %0d", k - 1, RT); end
      if (err !== 1'b1) begin n_bad++; $display("FAIL tmo_err: got %b expected 1", err); end
      if (wv_cnt != w0) begin n_bad++; $display("FAIL tmo_no_words: got %0d valid cycles expected 0", wv_cnt - w0); end
    end
`else
    repeat (300) @(negedge clk);
    n_cmp += 5;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL notmo_busy: got %b expected 1", busy); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL notmo_err: got %b expected 0", err); end
    if (d_en !== 1'b0) begin n_bad++; $display("FAIL notmo_d_en: got %b expected 0", d_en); end
    if (wv_cnt != w0) begin n_bad++; $display("FAIL notmo_no_words: got %0d valid cycles expected 0", wv_cnt - w0); end
    rst = 1'b0;
    #1;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL notmo_reset_busy: got %b expected 0", busy); end
    @(negedge clk) rst = 1'b1;
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_random();
    test_reset_mid();
    test_sdone_fault();
    test_start_ignored();
    test_timeout();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
